pipe_hazard_ctrl: RTL and testbench

- Central stall/flush controller for the 5-stage RV32 pipeline (IF, ID, EX, MEM, WB).
- Drives enable/flush of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Resolves load-use hazards, taken-branch redirects, instruction-fetch misses and multi-cycle data-memory waits.
- Runs a data-memory wait FSM with a timeout watchdog; sits beside the datapath and feeds every pipeline register.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 33 +++
 rtl/pipe_hazard_ctrl_hazard_detect.sv | 23 ++
 rtl/pipe_hazard_ctrl.sv | 163 ++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared pipeline definitions for the hazard controller: FSM states, register-index
// constants and the bundled enable/flush control word.
package pipe_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DWAIT = 2'd1,
    ERR   = 2'd2
  } haz_state_e;

  localparam int REG_IDX_W = 5;
  localparam logic [REG_IDX_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic idex_en;
    logic exmem_en;
    logic memwb_en;
    logic ifid_flush;
    logic idex_flush;
  } pipe_ctrl_t;

  // Normal flow: every stage advances, nothing squashed.
  function automatic pipe_ctrl_t ctrl_run();
    pipe_ctrl_t c;
    c            = '1;
    c.ifid_flush = 1'b0;
    c.idex_flush = 1'b0;
    return c;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Combinational load-use hazard compare between the ID instruction's sources and a
// load sitting in EX; shared with the forwarding unit.
module hazard_detect
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic [REG_IDX_W-1:0] id_rs1_addr,
  input  logic [REG_IDX_W-1:0] id_rs2_addr,
  input  logic                 id_rs1_used,
  input  logic                 id_rs2_used,
  input  logic                 ex_mem_read,
  input  logic [REG_IDX_W-1:0] ex_rd_addr,
  output logic                 load_use
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit  = id_rs1_used && (id_rs1_addr == ex_rd_addr);
  assign rs2_hit  = id_rs2_used && (id_rs2_addr == ex_rd_addr);
  // x0 is hardwired to zero, so a load "writing" it never creates a dependency.
  assign load_use = ex_mem_read && (ex_rd_addr != REG_ZERO) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline with a data-memory wait FSM and
// timeout watchdog. Optional perf counters are built when HAZ_PERF_CNT_EN is defined.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int WAIT_TIMEOUT = 256,
  parameter int CNT_W        = 9
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs1_addr,
  input  logic [4:0]  id_rs2_addr,
  input  logic        id_rs1_used,
  input  logic        id_rs2_used,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_rd_addr,
  input  logic        ex_branch_taken,
  input  logic        imem_ready,
  input  logic        dmem_req,
  input  logic        dmem_ready,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        idex_en,
  output logic        exmem_en,
  output logic        memwb_en,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        haz_err
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [31:0] perf_stall_cyc,
  output logic [31:0] perf_flush_evt
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] TIMEOUT = CNT_W'(WAIT_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  haz_state_e       state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  pipe_ctrl_t       prio_ctrl;
  pipe_ctrl_t       ctrl;
  logic             load_use;
  logic             dstall;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  function automatic logic timed_out(input logic [CNT_W-1:0] v);
    return (WAIT_TIMEOUT != 0) && (v >= TIMEOUT);
  endfunction

  hazard_detect u_hazard_detect (
    .id_rs1_addr (id_rs1_addr),
    .id_rs2_addr (id_rs2_addr),
    .id_rs1_used (id_rs1_used),
    .id_rs2_used (id_rs2_used),
    .ex_mem_read (ex_mem_read),
    .ex_rd_addr  (ex_rd_addr),
    .load_use    (load_use)
  );

  assign dstall = dmem_req && !dmem_ready;

  // Redirect beats load-use: the dependent ID instruction is squashed anyway.
  always_comb begin
    prio_ctrl = ctrl_run();
    if (ex_branch_taken) begin
      prio_ctrl.ifid_flush = 1'b1;
      prio_ctrl.idex_flush = 1'b1;
    end else if (load_use) begin
      prio_ctrl.pc_en      = 1'b0;
      prio_ctrl.ifid_en    = 1'b0;
      prio_ctrl.idex_flush = 1'b1;
    end else if (!imem_ready) begin
      prio_ctrl.pc_en      = 1'b0;
      prio_ctrl.ifid_flush = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    ctrl       = '0;
    case (state_q)
      RUN: begin
        if (dstall) begin
          wait_cnt_d = CNT_ONE;
          state_d    = timed_out(CNT_ONE) ? ERR : DWAIT;
        end else begin
          ctrl = prio_ctrl;
        end
      end
      DWAIT: begin
        // A branch held in EX during the freeze is honoured here on release.
        if (!dmem_ready) begin
          wait_cnt_d = sat_inc(wait_cnt_q);
          state_d    = timed_out(wait_cnt_d) ? ERR : DWAIT;
        end else begin
          ctrl       = prio_ctrl;
          wait_cnt_d = '0;
          state_d    = RUN;
        end
      end
      ERR: begin
        ctrl = '0;
      end
      default: begin
        wait_cnt_d = '0;
        state_d    = RUN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign pc_en      = rst && ctrl.pc_en;
  assign ifid_en    = rst && ctrl.ifid_en;
  assign idex_en    = rst && ctrl.idex_en;
  assign exmem_en   = rst && ctrl.exmem_en;
  assign memwb_en   = rst && ctrl.memwb_en;
  assign ifid_flush = rst && ctrl.ifid_flush;
  assign idex_flush = rst && ctrl.idex_flush;
  assign haz_err    = (state_q == ERR);

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] perf_stall_q, perf_stall_d;
  logic [31:0] perf_flush_q, perf_flush_d;

  always_comb begin
    perf_stall_d = perf_stall_q;
    perf_flush_d = perf_flush_q;
    if (state_q != ERR) begin
      if (!ctrl.pc_en)     perf_stall_d = perf_stall_q + 32'd1;
      if (ctrl.idex_flush) perf_flush_d = perf_flush_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_flush_q <= perf_flush_d;
    end
  end

  assign perf_stall_cyc = perf_stall_q;
  assign perf_flush_evt = perf_flush_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: rule-level reference model checked every cycle
// plus hand-computed expectations for each scenario.
module tb_pipe_hazard_ctrl;

  localparam int WT      = 4;
  localparam int CW      = 9;
  localparam int CNT_MAX = (1 << CW) - 1;

  // Output word order: pc, ifid, idex, exmem, memwb, ifid_flush, idex_flush, haz_err
  localparam logic [7:0] O_RST    = 8'h00;
  localparam logic [7:0] O_FREEZE = 8'h00;
  localparam logic [7:0] O_RUN    = 8'hF8;
  localparam logic [7:0] O_BR     = 8'hFE;
  localparam logic [7:0] O_LU     = 8'h3A;
  localparam logic [7:0] O_IMISS  = 8'h7C;
  localparam logic [7:0] O_ERR    = 8'h01;
  localparam logic [7:0] M_ALL    = 8'hFF;
  localparam logic [7:0] M_LU     = 8'hDF;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [4:0] id_rs1_addr, id_rs2_addr, ex_rd_addr;
  logic id_rs1_used, id_rs2_used, ex_mem_read, ex_branch_taken;
  logic imem_ready, dmem_req, dmem_ready;
  logic pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, haz_err;
  logic [7:0] outs;
`ifdef HAZ_PERF_CNT_EN
  logic [31:0] perf_stall_cyc, perf_flush_evt;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  pipe_hazard_ctrl #(.WAIT_TIMEOUT(WT), .CNT_W(CW)) dut (
    .clk             (clk),
    .rst             (rst),
    .id_rs1_addr     (id_rs1_addr),
    .id_rs2_addr     (id_rs2_addr),
    .id_rs1_used     (id_rs1_used),
    .id_rs2_used     (id_rs2_used),
    .ex_mem_read     (ex_mem_read),
    .ex_rd_addr      (ex_rd_addr),
    .ex_branch_taken (ex_branch_taken),
    .imem_ready      (imem_ready),
    .dmem_req        (dmem_req),
    .dmem_ready      (dmem_ready),
    .pc_en           (pc_en),
    .ifid_en         (ifid_en),
    .idex_en         (idex_en),
    .exmem_en        (exmem_en),
    .memwb_en        (memwb_en),
    .ifid_flush      (ifid_flush),
    .idex_flush      (idex_flush),
    .haz_err         (haz_err)
`ifdef HAZ_PERF_CNT_EN
    ,
    .perf_stall_cyc  (perf_stall_cyc),
    .perf_flush_evt  (perf_flush_evt)
`endif
  );

  always #5 clk = ~clk;

  assign outs = {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, haz_err};

  // Reference model: mode 0 = running, 1 = waiting on data memory, 2 = dead (watchdog)
  int          m_mode  = 0;
  int          m_cnt   = 0;
  logic [31:0] m_stall = '0;
  logic [31:0] m_flush = '0;
  logic        m_lu;
  logic [7:0]  m_exp;

  always_comb begin
    m_lu = 1'b0;
    if (ex_mem_read && ex_rd_addr != 5'd0 &&
        ((id_rs1_used && id_rs1_addr == ex_rd_addr) || (id_rs2_used && id_rs2_addr == ex_rd_addr)))
      m_lu = 1'b1;
  end

  always_comb begin
    m_exp = O_RUN;
    if (!rst)                                          m_exp = O_RST;
    else if (m_mode == 2)                              m_exp = O_ERR;
    else if (!dmem_ready && (m_mode == 1 || dmem_req)) m_exp = O_FREEZE;
    else if (ex_branch_taken)                          m_exp = O_BR;
    else if (m_lu)                                     m_exp = O_LU;
    else if (!imem_ready)                              m_exp = O_IMISS;
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_mode  <= 0;
      m_cnt   <= 0;
      m_stall <= '0;
      m_flush <= '0;
    end else begin
      if (m_mode != 2) begin
        if (!m_exp[7]) m_stall <= m_stall + 32'd1;
        if (m_exp[1])  m_flush <= m_flush + 32'd1;
      end
      if (m_mode == 0 && dmem_req && !dmem_ready) begin
        m_cnt  <= 1;
        m_mode <= (WT != 0 && 1 >= WT) ? 2 : 1;
      end else if (m_mode == 1) begin
        if (!dmem_ready) begin
          m_cnt  <= (m_cnt + 1 > CNT_MAX) ? m_cnt : m_cnt + 1;
          m_mode <= (WT != 0 && m_cnt + 1 >= WT) ? 2 : 1;
        end else begin
          m_cnt  <= 0;
          m_mode <= 0;
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    n_chk++;
    if (outs !== m_exp) begin
      n_fail++;
      $display("FAIL model_cmp t=%0t got=%b want=%b", $time, outs, m_exp);
    end
`ifdef HAZ_PERF_CNT_EN
    n_chk++;
    if (perf_stall_cyc !== m_stall || perf_flush_evt !== m_flush) begin
      n_fail++;
      $display("FAIL perf_cmp t=%0t got=%0d/%0d want=%0d/%0d", $time,
               perf_stall_cyc, perf_flush_evt, m_stall, m_flush);
    end
`endif
  end

  task automatic chk(input string name, input logic [7:0] want, input logic [7:0] mask);
    n_chk++;
    if ((outs & mask) !== (want & mask)) begin
      n_fail++;
      $display("FAIL %s t=%0t got=%b want=%b mask=%b", name, $time, outs, want, mask);
    end
  endtask

  task automatic idle();
    id_rs1_addr = 5'd0; id_rs2_addr = 5'd0; ex_rd_addr = 5'd0;
    id_rs1_used = 1'b0; id_rs2_used = 1'b0; ex_mem_read = 1'b0;
    ex_branch_taken = 1'b0; imem_ready = 1'b1; dmem_req = 1'b0; dmem_ready = 1'b0;
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout t=%0t", $time);
    $fatal(1, "bench timeout");
  end

  initial begin
    idle();
    @(negedge clk); chk("reset_outs", O_RST, M_ALL);
    next(); rst = 1'b1;
    @(negedge clk); chk("idle_run", O_RUN, M_ALL);

    next(); ex_mem_read = 1; ex_rd_addr = 5; id_rs1_addr = 5; id_rs1_used = 1;
    @(negedge clk); chk("load_use_rs1", O_LU, M_LU);
    next(); idle();
    @(negedge clk); chk("after_load_use", O_RUN, M_ALL);

    next(); ex_mem_read = 1; ex_rd_addr = 7; id_rs2_addr = 7; id_rs2_used = 1; id_rs1_addr = 7;
    @(negedge clk); chk("load_use_rs2", O_LU, M_LU);
    next(); id_rs2_used = 0;
    @(negedge clk); chk("unused_src", O_RUN, M_ALL);

    next(); idle(); ex_mem_read = 1; ex_rd_addr = 0; id_rs1_addr = 0; id_rs1_used = 1;
    @(negedge clk); chk("x0_guard", O_RUN, M_ALL);

    next(); ex_rd_addr = 5; id_rs1_addr = 5; ex_branch_taken = 1;
    @(negedge clk); chk("branch_over_lu", O_BR, M_ALL);

    next(); idle(); imem_ready = 0;
    @(negedge clk); chk("imem_miss", O_IMISS, M_ALL);

    next(); idle(); dmem_req = 1; dmem_ready = 0; ex_branch_taken = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); chk("dwait_freeze_br", O_FREEZE, M_ALL);
      next();
    end
    dmem_ready = 1;
    @(negedge clk); chk("dwait_release_br", O_BR, M_ALL);
    next(); idle();
    @(negedge clk); chk("run_after_wait", O_RUN, M_ALL);

    next(); dmem_req = 1; dmem_ready = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); chk("dwait_freeze", O_FREEZE, M_ALL);
      next();
    end
    dmem_ready = 1;
    @(negedge clk); chk("dwait_release", O_RUN, M_ALL);

    next(); idle(); dmem_req = 1; dmem_ready = 0;
    @(negedge clk); chk("pre_reset_freeze", O_FREEZE, M_ALL);
    next(); dmem_ready = 1;
    #1 chk("dwait_open", O_RUN, M_ALL);
    #2 rst = 1'b0;
    #1 chk("async_reset", O_RST, M_ALL);
`ifdef HAZ_PERF_CNT_EN
    n_chk++;
    if (perf_stall_cyc !== 32'd0 || perf_flush_evt !== 32'd0) begin
      n_fail++;
      $display("FAIL perf_reset got=%0d/%0d want=0/0", perf_stall_cyc, perf_flush_evt);
    end
`endif
    next(); rst = 1'b1; idle();
    @(negedge clk); chk("run_after_reset", O_RUN, M_ALL);

    next(); dmem_req = 1; dmem_ready = 0;
    for (int i = 0; i < WT; i++) begin
      @(negedge clk); chk("wd_wait", O_FREEZE, M_ALL);
      next();
    end
    @(negedge clk); chk("wd_err", O_ERR, M_ALL);
    next(); dmem_ready = 1; ex_branch_taken = 1;
    @(negedge clk); chk("wd_sticky", O_ERR, M_ALL);
    next();
    @(negedge clk); chk("wd_sticky2", O_ERR, M_ALL);
    #2 rst = 1'b0;
    #1 chk("wd_reset", O_RST, M_ALL);
    next(); rst = 1'b1; idle();
    @(negedge clk); chk("wd_recovered", O_RUN, M_ALL);

    next();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
